// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
//
// Serialises parallel words onto an asynchronous serial line. Each frame is one
// start bit (0), FRAME_DATA_LENGTH data bits and one stop bit (1). Every bit is
// held for CLKS_PER_BIT clock cycles. A one-word holding register lets the
// next word be queued while a frame is on the line, so frames can follow each
// other with no idle gap.
//
// Parameters
//   NATIVE_CLK_FREQUENCY  clk frequency in Hz
//   BAUDRATE              line bit rate; CLKS_PER_BIT = NATIVE_CLK_FREQUENCY / BAUDRATE
//   FRAME_DATA_LENGTH     data bits per frame
//   BIG_ENDIAN            0 = LSB first on the line, 1 = MSB first
//
// Ports
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   data_in  in   word to transmit (bit 0 is the numeric LSB)
//   send     in   request; accepted on a rising edge where send && ready
//   ready    out  high when a word can be accepted this cycle
//   tx       out  registered serial line, idle high
//   busy     out  high while a frame is on the line or a word is queued
// ---------------------------------------------------------------------------
module uart_transmitter #(
    parameter int NATIVE_CLK_FREQUENCY = 1000000000,
    parameter int BAUDRATE             = 9600,
    parameter int FRAME_DATA_LENGTH    = 8,
    parameter int BIG_ENDIAN           = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [FRAME_DATA_LENGTH-1:0] data_in,
    input  logic                         send,
    output logic                         ready,
    output logic                         tx,
    output logic                         busy
);

    localparam int CLKS_PER_BIT = NATIVE_CLK_FREQUENCY / BAUDRATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(FRAME_DATA_LENGTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_DATA_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                         state;
    logic [CNT_W-1:0]               baud_cnt;
    logic [IDX_W-1:0]               bit_idx;
    logic [FRAME_DATA_LENGTH-1:0]   shift_reg;
    logic [FRAME_DATA_LENGTH-1:0]   hold_reg;
    logic                           hold_full;

    logic                           accept;
    logic                           baud_done;
    logic                           direct_load;
    logic [FRAME_DATA_LENGTH-1:0]   shift_next;

    // The bit that goes on the line next is always at the "head" end of the
    // shift register; which end that is depends on the transmission order.
    function automatic logic head_bit(input logic [FRAME_DATA_LENGTH-1:0] v);
        return (BIG_ENDIAN != 0) ? v[FRAME_DATA_LENGTH-1] : v[0];
    endfunction

    // Handshake and bit-timing helpers. A word bypasses the holding register
    // when the line is idle, or when it arrives on the very edge that ends a
    // stop bit with nothing queued, so it is neither lost nor delayed.
    assign ready       = ~hold_full;
    assign accept      = send & ready;
    assign baud_done   = (baud_cnt == CNT_LAST);
    assign direct_load = (state == IDLE) || ((state == STOP) && baud_done);
    assign shift_next  = (BIG_ENDIAN != 0) ? (shift_reg << 1) : (shift_reg >> 1);
    assign busy        = (state != IDLE) || hold_full;

    // Frame sequencer: walks IDLE -> START -> DATA -> STOP, holding each bit for
    // CLKS_PER_BIT cycles. tx is registered and always set together with the
    // state it belongs to, so the line changes on the same edge as the state.
    // The holding register is written at the bottom for accepts that cannot
    // go straight into the shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    tx       <= 1'b1;
                    if (accept) begin
                        shift_reg <= data_in;
                        state     <= START;
                        tx        <= 1'b0;
                    end
                end

                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= head_bit(shift_reg);
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_next;
                            tx        <= head_bit(shift_next);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (hold_full) begin
                            shift_reg <= hold_reg;
                            hold_full <= 1'b0;
                            tx        <= 1'b0;
                            state     <= START;
                        end else if (accept) begin
                            shift_reg <= data_in;
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase

            if (accept && !direct_load) begin
                hold_reg  <= data_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
//
// Drives two transmitters (LSB-first and MSB-first) with the same stimulus.
// A frame-level model predicts tx/ready/busy every cycle from "which word is
// on the line and how far into its frame are we". Two line receivers decode
// what actually appears on each tx line so directed tests can check literal
// words, bit orders and busy durations.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int CLK_HZ      = 160;
    localparam int BAUD        = 10;
    localparam int CLKS        = CLK_HZ / BAUD;
    localparam int NBITS       = 8;
    localparam int FRAME_CYCLES = CLKS * (NBITS + 2);

    logic             clk;
    logic             reset_n;
    logic [NBITS-1:0] data_in;
    logic             send;
    logic             ready_le, tx_le, busy_le;
    logic             ready_be, tx_be, busy_be;

    int checks = 0;
    int errors = 0;
    int busy_total = 0;
    int tx_low_total = 0;
    int frame_errs = 0;

    logic [7:0] rx_word_le[$];
    logic [7:0] rx_raw_le[$];
    logic [7:0] rx_word_be[$];
    logic [7:0] rx_raw_be[$];

    uart_transmitter #(
        .NATIVE_CLK_FREQUENCY(CLK_HZ),
        .BAUDRATE(BAUD),
        .FRAME_DATA_LENGTH(NBITS),
        .BIG_ENDIAN(0)
    ) dut_le (
        .clk(clk),
        .reset_n(reset_n),
        .data_in(data_in),
        .send(send),
        .ready(ready_le),
        .tx(tx_le),
        .busy(busy_le)
    );

    uart_transmitter #(
        .NATIVE_CLK_FREQUENCY(CLK_HZ),
        .BAUDRATE(BAUD),
        .FRAME_DATA_LENGTH(NBITS),
        .BIG_ENDIAN(1)
    ) dut_be (
        .clk(clk),
        .reset_n(reset_n),
        .data_in(data_in),
        .send(send),
        .ready(ready_be),
        .tx(tx_be),
        .busy(busy_be)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame-level reference: a word is either on the line (with its age in
    // cycles since the start bit began) or waiting in a one-deep queue.
    logic       m_active = 1'b0;
    logic       m_pend   = 1'b0;
    logic [7:0] m_word   = 8'h00;
    logic [7:0] m_pend_word = 8'h00;
    int         m_age    = 0;
    logic       m_rdy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_age    = 0;
        end else begin
            m_rdy = !m_pend;
            if (m_active) begin
                m_age = m_age + 1;
                if (m_age == FRAME_CYCLES) begin
                    if (m_pend) begin
                        m_word = m_pend_word;
                        m_pend = 1'b0;
                        m_age  = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end
            if (send && m_rdy) begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_word   = data_in;
                    m_age    = 0;
                end else begin
                    m_pend      = 1'b1;
                    m_pend_word = data_in;
                end
            end
        end
    end

    // Expected line level: slot 0 is the start bit, slots 1..8 data, 9 stop.
    function automatic logic expTx(input bit be);
        int slot;
        if (!m_active) return 1'b1;
        slot = m_age / CLKS;
        if (slot == 0) return 1'b0;
        if (slot >= NBITS + 1) return 1'b1;
        return be ? m_word[NBITS - slot] : m_word[slot - 1];
    endfunction

    function automatic logic lineOf(input bit be);
        return be ? tx_be : tx_le;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word);
        send    = 1'b1;
        data_in = word;
        @(posedge clk);
        #2;
        send    = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic waitReady(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (ready_le) break;
            idleCycles(1);
        end
        if (i == limit) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitNeg(input int n, output logic alive);
        alive = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!reset_n) begin
                alive = 1'b0;
                return;
            end
        end
    endtask

    // Every-cycle comparison of both DUTs against the reference, sampled on
    // the falling edge so registered outputs have settled.
    task automatic compareLoop();
        forever begin
            @(negedge clk);
            checkOutput("tx_le", tx_le, expTx(1'b0));
            checkOutput("tx_be", tx_be, expTx(1'b1));
            checkOutput("ready_le", ready_le, !m_pend);
            checkOutput("ready_be", ready_be, !m_pend);
            checkOutput("busy_le", busy_le, m_active || m_pend);
            checkOutput("busy_be", busy_be, m_active || m_pend);
            if (busy_le) busy_total++;
            if (!tx_le) tx_low_total++;
        end
    endtask

    // Line receiver: finds a falling edge, samples each bit mid-way, and
    // records the decoded word plus the raw data bits in arrival order
    // (first bit received lands in the MSB of raw). Frames cut by reset
    // are dropped.
    task automatic rxLoop(input bit be);
        logic [9:0] bits;
        logic [7:0] word, raw;
        logic       alive;
        forever begin
            @(negedge clk);
            if (reset_n && lineOf(be) == 1'b0) begin
                alive = 1'b1;
                bits  = '0;
                for (int s = 0; s < NBITS + 2 && alive; s++) begin
                    waitNeg((s == 0) ? (CLKS / 2 - 1) : CLKS, alive);
                    bits[s] = lineOf(be);
                end
                if (alive) begin
                    if (bits[0] !== 1'b0 || bits[NBITS+1] !== 1'b1) frame_errs++;
                    for (int k = 0; k < NBITS; k++) begin
                        raw[NBITS-1-k] = bits[k+1];
                        if (be) word[NBITS-1-k] = bits[k+1];
                        else    word[k]         = bits[k+1];
                    end
                    if (be) begin
                        rx_word_be.push_back(word);
                        rx_raw_be.push_back(raw);
                    end else begin
                        rx_word_le.push_back(word);
                        rx_raw_le.push_back(raw);
                    end
                end
            end
        end
    endtask

    function automatic logic [7:0] rxAt(input bit be, input bit raw, input int idx);
        if (be) begin
            if (idx >= rx_word_be.size()) return 8'hxx;
            return raw ? rx_raw_be[idx] : rx_word_be[idx];
        end
        if (idx >= rx_word_le.size()) return 8'hxx;
        return raw ? rx_raw_le[idx] : rx_word_le[idx];
    endfunction

    task automatic mainSequence();
        int busy0, low0, base_le, base_be;

        reset_n = 1'b0;
        send    = 1'b0;
        data_in = 8'h00;
        idleCycles(3);
        reset_n = 1'b1;

        // Idle after reset: line high, nothing busy.
        $display("[TB] idle after reset");
        busy0 = busy_total;
        low0  = tx_low_total;
        idleCycles(50);
        checkOutput("idle_busy_cycles", busy_total - busy0, 0);
        checkOutput("idle_tx_low_cycles", tx_low_total - low0, 0);
        checkOutput("idle_ready", ready_le, 1);

        // Single 0xA5 frame on both orders.
        $display("[TB] single frame 0xA5");
        busy0 = busy_total; base_le = rx_word_le.size(); base_be = rx_word_be.size();
        applyStimulus(8'hA5);
        idleCycles(200);
        checkOutput("a5_busy_cycles", busy_total - busy0, 160);
        checkOutput("a5_le_count", rx_word_le.size() - base_le, 1);
        checkOutput("a5_le_word", rxAt(0, 0, base_le), 8'hA5);
        checkOutput("a5_le_raw", rxAt(0, 1, base_le), 8'hA5);
        checkOutput("a5_be_word", rxAt(1, 0, base_be), 8'hA5);
        checkOutput("a5_be_raw", rxAt(1, 1, base_be), 8'hA5);

        // 0x01 distinguishes the two bit orders on the line.
        $display("[TB] single frame 0x01");
        base_le = rx_word_le.size(); base_be = rx_word_be.size();
        applyStimulus(8'h01);
        idleCycles(200);
        checkOutput("x01_le_word", rxAt(0, 0, base_le), 8'h01);
        checkOutput("x01_le_raw", rxAt(0, 1, base_le), 8'h80);
        checkOutput("x01_be_word", rxAt(1, 0, base_be), 8'h01);
        checkOutput("x01_be_raw", rxAt(1, 1, base_be), 8'h01);

        // Queue a second word, then try a third while full.
        $display("[TB] back-to-back with ignored third send");
        busy0 = busy_total; base_le = rx_word_le.size();
        applyStimulus(8'h3C);
        idleCycles(20);
        applyStimulus(8'hC3);
        idleCycles(1);
        applyStimulus(8'h77);
        idleCycles(136);
        checkOutput("b2b_ready_before_switch", ready_le, 0);
        idleCycles(1);
        checkOutput("b2b_ready_after_switch", ready_le, 1);
        checkOutput("b2b_start_bit", tx_le, 0);
        idleCycles(300);
        checkOutput("b2b_busy_cycles", busy_total - busy0, 320);
        checkOutput("b2b_count", rx_word_le.size() - base_le, 2);
        checkOutput("b2b_word0", rxAt(0, 0, base_le), 8'h3C);
        checkOutput("b2b_word1", rxAt(0, 0, base_le + 1), 8'hC3);

        // Send lands exactly on the edge that ends the stop bit.
        $display("[TB] send on stop-bit end edge");
        busy0 = busy_total; base_be = rx_word_be.size();
        applyStimulus(8'h96);
        idleCycles(159);
        applyStimulus(8'h4B);
        idleCycles(400);
        checkOutput("edge_busy_cycles", busy_total - busy0, 320);
        checkOutput("edge_count", rx_word_be.size() - base_be, 2);
        checkOutput("edge_word0", rxAt(1, 0, base_be), 8'h96);
        checkOutput("edge_word1", rxAt(1, 0, base_be + 1), 8'h4B);

        // Reset mid-frame with a word queued, then send in first cycle after.
        $display("[TB] reset mid-frame");
        base_le = rx_word_le.size(); base_be = rx_word_be.size();
        applyStimulus(8'hFF);
        applyStimulus(8'h12);
        repeat (69) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_tx_le", tx_le, 1);
        checkOutput("rst_tx_be", tx_be, 1);
        checkOutput("rst_ready", ready_le, 1);
        checkOutput("rst_busy_le", busy_le, 0);
        checkOutput("rst_busy_be", busy_be, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        applyStimulus(8'h00);
        idleCycles(200);
        checkOutput("rst_le_count", rx_word_le.size() - base_le, 1);
        checkOutput("rst_le_word", rxAt(0, 0, base_le), 8'h00);
        checkOutput("rst_be_word", rxAt(1, 0, base_be), 8'h00);

        // Four words streamed back-to-back.
        $display("[TB] loopback stream");
        busy0 = busy_total; base_le = rx_word_le.size(); base_be = rx_word_be.size();
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        waitReady(400);
        applyStimulus(8'h55);
        waitReady(400);
        applyStimulus(8'hAA);
        idleCycles(500);
        checkOutput("loop_busy_cycles", busy_total - busy0, 640);
        checkOutput("loop_count", rx_word_le.size() - base_le, 4);
        checkOutput("loop_w0", rxAt(0, 0, base_le), 8'h00);
        checkOutput("loop_w1", rxAt(0, 0, base_le + 1), 8'hFF);
        checkOutput("loop_w2", rxAt(0, 0, base_le + 2), 8'h55);
        checkOutput("loop_w3", rxAt(0, 0, base_le + 3), 8'hAA);
        checkOutput("loop_be_w2", rxAt(1, 0, base_be + 2), 8'h55);
        checkOutput("loop_be_w3", rxAt(1, 0, base_be + 3), 8'hAA);

        checkOutput("frame_errors", frame_errs, 0);
    endtask

    initial begin
        fork
            compareLoop();
            rxLoop(1'b0);
            rxLoop(1'b1);
            mainSequence();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
